// File: rtl/ssd_capture.sv
`default_nettype none
// ============================================================================
// Module      : ssd_capture
// Description : Recovers the hex digits shown on a multiplexed, active-low
//               seven-segment display by watching its digit enables and
//               segment lines. A pattern must stay stable before it is
//               captured. Captured digits fill a staging frame. The frame is
//               published on numbers once every digit has been seen.
//               Optional feature macro: SSD_CAPTURE_ERR_COUNT_EN adds an
//               8-bit saturating count of rejected captures (err_count).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_capture #(
    parameter int DIGITS = 8,   // multiplexed displays, 1..8
    parameter int STABLE = 4    // cycles a pattern must hold, 2..255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     displays,
    input  logic [6:0]            segments,
    output logic [4*DIGITS-1:0]   numbers,
    output logic [DIGITS-1:0]     seen,
    output logic                  frame_valid,
    output logic                  pattern_err
`ifdef SSD_CAPTURE_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam logic [7:0]        c_STABLE    = 8'(STABLE);
    localparam logic [7:0]        c_STABLE_M1 = 8'(STABLE - 1);
    localparam logic [DIGITS-1:0] c_ONE       = DIGITS'(1);
    localparam logic [6:0]        c_BLANK     = 7'h7F;

    // Registered copy of the display bus and its previous value
    logic [DIGITS-1:0]   r_disp;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_prev_disp;
    logic [6:0]          r_prev_seg;

    logic [7:0]          r_stab_cnt;
    logic [4*DIGITS-1:0] r_staging;
    logic [4*DIGITS-1:0] r_numbers;
    logic [DIGITS-1:0]   r_seen;
    logic                r_frame_valid;
    logic                r_pattern_err;

    logic                w_pat_same;
    logic                w_capture;
    logic [DIGITS-1:0]   w_low;
    logic                w_ignore;
    logic                w_one_low;
    logic [4:0]          w_dec;
    logic                w_write;
    logic                w_err;
    logic                w_frame_done;

    // Segment decode: returns {valid, nibble}; anything outside the table is invalid
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // A capture fires only on the cycle the counter steps onto STABLE, and a
    // pattern change on that same cycle suppresses it.
    assign w_pat_same   = (r_disp == r_prev_disp) && (r_seg == r_prev_seg);
    assign w_capture    = w_pat_same && (r_stab_cnt == c_STABLE_M1);

    // Blank display (no digit enabled or all segments off) is not an error.
    assign w_low        = ~r_disp;
    assign w_ignore     = (&r_disp) || (r_seg == c_BLANK);
    assign w_one_low    = ((w_low & (w_low - c_ONE)) == '0) && (w_low != '0);
    assign w_dec        = f_decode(r_seg);

    assign w_write      = w_capture && !w_ignore && w_one_low && w_dec[4];
    assign w_err        = w_capture && !w_ignore && (!w_one_low || !w_dec[4]);
    assign w_frame_done = &r_seen;

    // Input register plus one-cycle history for change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp      <= '1;
            r_seg       <= '1;
            r_prev_disp <= '1;
            r_prev_seg  <= '1;
        end else begin
            r_disp      <= displays;
            r_seg       <= segments;
            r_prev_disp <= r_disp;
            r_prev_seg  <= r_seg;
        end
    end

    // Stability counter: restarts on any change, saturates at STABLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stab_cnt <= '0;
        end else if (!w_pat_same) begin
            r_stab_cnt <= '0;
        end else if (r_stab_cnt != c_STABLE) begin
            r_stab_cnt <= r_stab_cnt + 8'd1;
        end
    end

    // Staging slots, seen mask and frame publication one edge after completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_staging     <= '0;
            r_seen        <= '0;
            r_numbers     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_frame_done) begin
                r_numbers     <= r_staging;
                r_seen        <= '0;
                r_frame_valid <= 1'b1;
            end else if (w_write) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (w_low[i]) begin
                        r_staging[4*i +: 4] <= w_dec[3:0];
                        r_seen[i]           <= 1'b1;
                    end
                end
            end
        end
    end

    // One-cycle pulse for each rejected capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern_err <= 1'b0;
        end else begin
            r_pattern_err <= w_err;
        end
    end

`ifdef SSD_CAPTURE_ERR_COUNT_EN
    logic [7:0] r_err_count;

    // Saturating count of rejected captures
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign numbers     = r_numbers;
    assign seen        = r_seen;
    assign frame_valid = r_frame_valid;
    assign pattern_err = r_pattern_err;

endmodule
`default_nettype wire

// File: tb/tb_ssd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_capture
// Description : Scoreboard bench for ssd_capture (DIGITS=8, STABLE=4).
//               Stimulus pushes expected frame / error events into a queue;
//               a monitor pops and compares whenever frame_valid or
//               pattern_err pulses. Build with SSD_CAPTURE_ERR_COUNT_EN to
//               also check err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_capture;

    localparam int DIGITS = 8;
    localparam int STABLE = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [DIGITS-1:0]   displays;
    logic [6:0]          segments;
    logic [4*DIGITS-1:0] numbers;
    logic [DIGITS-1:0]   seen;
    logic                frame_valid;
    logic                pattern_err;
`ifdef SSD_CAPTURE_ERR_COUNT_EN
    logic [7:0]          err_count;
`endif

    typedef struct {
        bit          is_frame;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    ssd_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .displays    (displays),
        .segments    (segments),
        .numbers     (numbers),
        .seen        (seen),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err)
`ifdef SSD_CAPTURE_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Segment encoding of each hex digit (active low, {g,f,e,d,c,b,a})
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Drive a pattern starting at a falling edge and hold it n cycles
    task automatic hold(input logic [7:0] d, input logic [6:0] s, input int n);
        displays = d;
        segments = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit_mask(input int i, output logic [7:0] m);
        m = ~(8'h01 << i);
    endtask

    // Show digits lo..hi of val, 10 cycles each
    task automatic scan(input logic [31:0] val, input int lo, input int hi);
        logic [7:0] m;
        for (int i = lo; i <= hi; i++) begin
            digit_mask(i, m);
            hold(m, seg_of(val[4*i +: 4]), 10);
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (frame_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_event: unexpected frame_valid, numbers=%h", numbers);
                end else begin
                    e = q.pop_front();
                    if (!e.is_frame || numbers !== e.val) begin
                        bad++;
                        $display("FAIL frame_event: got frame numbers=%h required is_frame=%0d numbers=%h",
                                 numbers, e.is_frame, e.val);
                    end
                end
            end
            if (pattern_err === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL err_event: unexpected pattern_err");
                end else begin
                    e = q.pop_front();
                    if (e.is_frame) begin
                        bad++;
                        $display("FAIL err_event: got pattern_err required frame %h", e.val);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] m;
        reset    = 1'b1;
        displays = 8'hFF;
        segments = 7'h7F;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_numbers", numbers, 32'h0);
        check("rst_seen", seen, 32'h0);
        check("rst_frame_valid", frame_valid, 32'h0);
        check("rst_pattern_err", pattern_err, 32'h0);
`ifdef SSD_CAPTURE_ERR_COUNT_EN
        check("rst_err_count", err_count, 32'h0);
`endif
        reset = 1'b0;
        hold(8'hFF, 7'h7F, 4);

        // Scan 0x0130450B with a 2-cycle glitch (would write '8' into digit 1)
        q.push_back('{1'b1, 32'h0130450B});
        scan(32'h0130450B, 0, 2);
        hold(8'hFD, 7'h00, 2);
        hold(8'hF7, seg_of(4'h4), 3);
        check("glitch_seen", seen, 32'h07);
        hold(8'hF7, seg_of(4'h4), 7);
        scan(32'h0130450B, 4, 6);
        hold(8'h7F, seg_of(4'h0), 6);
        check("last_digit_seen", seen, 32'hFF);
        check("last_digit_fv_early", frame_valid, 32'h0);
        hold(8'h7F, seg_of(4'h0), 1);
        check("frame_pulse", frame_valid, 32'h1);
        check("frame_seen_clear", seen, 32'h0);
        hold(8'h7F, seg_of(4'h0), 3);
        hold(8'hFF, 7'h7F, 10);
        check("frame1_numbers", numbers, 32'h0130450B);
        check("frame1_fv_single", frame_valid, 32'h0);

        // Invalid segments on a single digit
        q.push_back('{1'b0, 32'h0});
        hold(8'hFE, 7'h55, 10);
        check("bad_seg_seen", seen, 32'h0);
`ifdef SSD_CAPTURE_ERR_COUNT_EN
        check("err_count_1", err_count, 32'd1);
`endif

        // Two digits enabled -> error; blank patterns -> silent
        q.push_back('{1'b0, 32'h0});
        hold(8'hFC, 7'h40, 10);
        hold(8'hFF, 7'h40, 10);
        hold(8'hFE, 7'h7F, 10);
        check("blank_seen", seen, 32'h0);
        check("numbers_hold", numbers, 32'h0130450B);
`ifdef SSD_CAPTURE_ERR_COUNT_EN
        check("err_count_2", err_count, 32'd2);
`endif

        // Partial frame then reset
        scan(32'h12345678, 0, 4);
        check("partial_seen", seen, 32'h1F);
        reset = 1'b1;
        hold(8'hFF, 7'h7F, 2);
        reset = 1'b0;
        check("midreset_seen", seen, 32'h0);
        check("midreset_numbers", numbers, 32'h0);
        hold(8'hFF, 7'h7F, 4);

        // Recapture digit 0 (F then 8), then full frame 0x12345678
        q.push_back('{1'b1, 32'h12345678});
        hold(8'hFE, seg_of(4'hF), 10);
        check("recap_seen_a", seen, 32'h01);
        hold(8'hFE, seg_of(4'h8), 10);
        check("recap_seen_b", seen, 32'h01);
        scan(32'h12345678, 1, 7);
        hold(8'hFF, 7'h7F, 10);
        check("frame2_numbers", numbers, 32'h12345678);

        // 300 rejected captures
        for (int k = 0; k < 300; k++) begin
            q.push_back('{1'b0, 32'h0});
            if (k % 2 == 0) hold(8'hFC, 7'h40, 6);
            else            hold(8'hFE, 7'h55, 6);
        end
        hold(8'hFF, 7'h7F, 10);
        check("numbers_after_errs", numbers, 32'h12345678);
        check("seen_after_errs", seen, 32'h0);
`ifdef SSD_CAPTURE_ERR_COUNT_EN
        check("err_count_sat", err_count, 32'd255);
`endif

        digit_mask(0, m);
        hold(m, 7'h7F, 10);
        check("queue_drained", q.size(), 32'h0);
        if (q.size() != 0) begin
            $display("FAIL missing_events: %0d expected events never seen", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 The module SHALL have parameter DIGITS, default 8, giving the number of multiplexed displays (range 1-8).
REQ-002 The module SHALL have parameter STABLE, default 4, giving the number of cycles an input pattern must hold before capture (range 2-255).
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 displays  input  DIGITS  active-low digit enables; bit i selects digit i.
REQ-007 segments  input  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-008 numbers  output  4*DIGITS  last complete frame; digit i at bits [4i+3:4i].
REQ-009 seen  output  DIGITS  digits captured in the current, incomplete frame.
REQ-010 frame_valid  output  1  one-cycle pulse when numbers updates.
REQ-011 pattern_err  output  1  one-cycle pulse on a rejected capture.

Function
REQ-012 {displays,segments} SHALL be registered once; all later logic SHALL use the registered copy.
REQ-013 The stability counter SHALL clear to 0 when the registered pattern differs from its previous value, and SHALL otherwise increment, saturating at STABLE.
REQ-014 A capture event SHALL occur only on the cycle the counter first reaches STABLE, giving exactly one capture per stable interval.
REQ-015 Decode (hex digit:segments) SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E; any other value is invalid.
REQ-016 A capture with displays all ones, or with segments = 7F, SHALL be ignored silently, with no write and no error.
REQ-017 A capture with exactly one displays bit low and a valid pattern SHALL write the nibble into staging slot i and set seen[i].
REQ-018 A capture with more than one displays bit low, or with an invalid segment pattern, SHALL pulse pattern_err for one cycle and SHALL write nothing.
REQ-019 Re-capture of a digit already in seen SHALL overwrite its staging slot and leave seen unchanged.
REQ-020 On the edge after the capture that completes seen, numbers SHALL load staging including that digit, frame_valid SHALL pulse for one cycle, and seen SHALL clear.
REQ-021 numbers SHALL hold its value between frames.
REQ-022 A pattern change on the same cycle the counter would reach STABLE SHALL suppress that capture.

Reset
REQ-023 On reset, numbers, seen, staging and the stability counter SHALL be 0, frame_valid and pattern_err SHALL be 0, and the input register SHALL be all ones.
REQ-024 Reset mid-frame SHALL discard partial digits; the next frame SHALL need all DIGITS captures again.

Configuration
REQ-025 With SSD_CAPTURE_ERR_COUNT_EN defined, output err_count[7:0] SHALL count pattern_err pulses, saturate at 255, and reset to 0.
REQ-026 Without SSD_CAPTURE_ERR_COUNT_EN, err_count and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Scan 0x0130450B, digits 0 to 7, 10 cycles each -> numbers = 0x0130450B, and frame_valid pulses once, one cycle after digit 7 is captured.
REQ-028 A 2-cycle glitch of displays = FD, segments = 00 inside a scan, with STABLE = 4 -> no capture, and seen is unchanged.
REQ-029 displays = FE, segments = 55 held 10 cycles -> one pattern_err pulse, seen[0] = 0, and err_count = 1 when enabled.
REQ-030 displays = FC, segments = 40 -> pattern_err pulse; displays = FF or segments = 7F -> no pulse.
REQ-031 Reset after 5 digits -> seen = 0 and numbers = 0; a full rescan of 0x12345678 -> numbers = 0x12345678.
REQ-032 300 invalid captures with the macro enabled -> err_count = 255.
